// File: rtl/cordic_seq.sv
// cordic_seq: CORDIC iteration sequencer (IDLE -> LOAD -> RUN -> HOLD), one rotation per request.
//   Ports: clk, rst (sync, active-high); start (request, IDLE only); busy (LOAD/RUN/HOLD);
//   ld (operand-load strobe, LOAD); step_en (iteration enable, RUN); iter (shift / atan-ROM address);
//   dout_valid (result ready, HOLD); dout_ack (consumer accept, HOLD only);
//   abort (cancel request, present only when CORDIC_SEQ_ABORT_EN is defined).
module cordic_seq #(
  parameter int ITERS = 13,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             ld,
  output logic             step_en,
  output logic [IDX_W-1:0] iter,
  output logic             dout_valid,
`ifdef CORDIC_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             dout_ack
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ITERS - 1);
  state_t           state_q, state_d;
  logic [IDX_W-1:0] iter_q, iter_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end
  // iter only advances in RUN and is cleared on leaving it, so it reads 0 everywhere else
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE: state_d = start ? LOAD : IDLE;
      LOAD: state_d = RUN;
      RUN: begin
        state_d = (iter_q == LAST) ? HOLD : RUN;
        iter_d  = (iter_q == LAST) ? '0 : iter_q + 1'b1;
      end
      HOLD: state_d = dout_ack ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
`ifdef CORDIC_SEQ_ABORT_EN
    // abort wins over everything, including start in IDLE and dout_ack in HOLD
    if (abort) begin
      state_d = IDLE;
      iter_d  = '0;
    end
`endif
  end
  always_comb begin
    busy       = state_q != IDLE;
    ld         = state_q == LOAD;
    step_en    = state_q == RUN;
    dout_valid = state_q == HOLD;
    iter       = iter_q;
  end
endmodule
